// File: rtl/fpu_pkg.sv
// Purpose : shared FPU operation codes and operand type for every FPU client and the FPU itself.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

    // Operation codes understood by the shared single-precision FPU.
    localparam logic [3:0] FPU_OP_ADD = 4'd0;
    localparam logic [3:0] FPU_OP_SUB = 4'd1;
    localparam logic [3:0] FPU_OP_MUL = 4'd2;
    localparam logic [3:0] FPU_OP_DIV = 4'd3;

    // Raw IEEE-754 single-precision bit pattern.
    typedef logic [31:0] fp32_t;

endpackage

// File: rtl/edge_function.sv
// Purpose : edge function z = (c0-a0)*(b1-a1) - (c1-a1)*(b0-a0), all arithmetic on a shared external FPU.
// Latency : 7 x (1 + FPU latency) + 1 cycles from the exec sample to done_strobe_o.
// Backpressure: starts are only accepted in IDLE; each FPU step waits for the FPU done strobe.
module edge_function
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] a_i [2],
    input  logic [31:0] b_i [2],
    input  logic [31:0] c_i [2],
    output logic [31:0] z_o,
    input  logic        exec_strobe_i,
    output logic        done_strobe_o,
    output logic [3:0]  fpu_op_o,
    output logic [31:0] fpu_a_value_o,
    output logic [31:0] fpu_b_value_o,
    input  logic [31:0] fpu_z_value_i,
    output logic        fpu_exec_strobe_o,
    input  logic        fpu_done_strobe_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Steps 0..5 land in tmp registers; step 6 is the final subtraction into z.
    localparam logic [2:0] LAST_STEP = 3'd6;
    localparam int         NUM_TMP   = 6;

    logic [1:0] state_q, state_d;
    logic [2:0] step_q,  step_d;
    fp32_t      a_q [2], a_d [2];
    fp32_t      b_q [2], b_d [2];
    fp32_t      c_q [2], c_d [2];
    fp32_t      tmp_q [NUM_TMP], tmp_d [NUM_TMP];
    fp32_t      z_q, z_d;

    logic [3:0] op_sel;
    fp32_t      opa_sel;
    fp32_t      opb_sel;
    logic       fpu_busy;

    // Operation and operands for the current step; minuend always on operand A.
    always_comb begin
        op_sel  = FPU_OP_SUB;
        opa_sel = '0;
        opb_sel = '0;
        case (step_q)
            3'd0: begin op_sel = FPU_OP_SUB; opa_sel = c_q[0];   opb_sel = a_q[0];   end
            3'd1: begin op_sel = FPU_OP_SUB; opa_sel = b_q[1];   opb_sel = a_q[1];   end
            3'd2: begin op_sel = FPU_OP_SUB; opa_sel = c_q[1];   opb_sel = a_q[1];   end
            3'd3: begin op_sel = FPU_OP_SUB; opa_sel = b_q[0];   opb_sel = a_q[0];   end
            3'd4: begin op_sel = FPU_OP_MUL; opa_sel = tmp_q[0]; opb_sel = tmp_q[1]; end
            3'd5: begin op_sel = FPU_OP_MUL; opa_sel = tmp_q[2]; opb_sel = tmp_q[3]; end
            default: begin op_sel = FPU_OP_SUB; opa_sel = tmp_q[4]; opb_sel = tmp_q[5]; end
        endcase
    end

    // Sequencer: capture inputs on start, issue one FPU op per step, collect results.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        z_d     = z_q;
        for (int i = 0; i < 2; i++) begin
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
            c_d[i] = c_q[i];
        end
        for (int i = 0; i < NUM_TMP; i++) begin
            tmp_d[i] = tmp_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (exec_strobe_i) begin
                    for (int i = 0; i < 2; i++) begin
                        a_d[i] = a_i[i];
                        b_d[i] = b_i[i];
                        c_d[i] = c_i[i];
                    end
                    step_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // FPU done strobes are only meaningful here; elsewhere they are stale.
                if (fpu_done_strobe_i) begin
                    if (step_q == LAST_STEP) begin
                        z_d     = fpu_z_value_i;
                        state_d = ST_DONE;
                    end else begin
                        for (int i = 0; i < NUM_TMP; i++) begin
                            if (step_q == 3'(i)) begin
                                tmp_d[i] = fpu_z_value_i;
                            end
                        end
                        step_d  = step_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset; reset also aborts any run.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            z_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
            for (int i = 0; i < NUM_TMP; i++) begin
                tmp_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            z_q     <= z_d;
            for (int i = 0; i < 2; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                c_q[i] <= c_d[i];
            end
            for (int i = 0; i < NUM_TMP; i++) begin
                tmp_q[i] <= tmp_d[i];
            end
        end
    end

    // Op/operands are held from ISSUE through WAIT so the FPU may sample them late.
    assign fpu_busy          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign fpu_op_o          = fpu_busy ? op_sel  : 4'd0;
    assign fpu_a_value_o     = fpu_busy ? opa_sel : 32'd0;
    assign fpu_b_value_o     = fpu_busy ? opb_sel : 32'd0;
    assign fpu_exec_strobe_o = (state_q == ST_ISSUE);
    assign done_strobe_o     = (state_q == ST_DONE);
    assign z_o               = z_q;

endmodule

// File: tb/tb_edge_function.sv
// Purpose : directed bench for edge_function with a behavioural FPU of programmable latency.
// Latency : fixed or random 1..10 cycle FPU latency per operation.
// Backpressure: FPU model accepts one operation at a time.
`timescale 1ns/1ps
module tb_edge_function;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] a_i [2];
    logic [31:0] b_i [2];
    logic [31:0] c_i [2];
    logic [31:0] z_o;
    logic        exec_strobe_i;
    logic        done_strobe_o;
    logic [3:0]  fpu_op_o;
    logic [31:0] fpu_a_value_o;
    logic [31:0] fpu_b_value_o;
    logic [31:0] fpu_z_value_i;
    logic        fpu_exec_strobe_o;
    logic        fpu_done_strobe_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edge_function dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .a_i               (a_i),
        .b_i               (b_i),
        .c_i               (c_i),
        .z_o               (z_o),
        .exec_strobe_i     (exec_strobe_i),
        .done_strobe_o     (done_strobe_o),
        .fpu_op_o          (fpu_op_o),
        .fpu_a_value_o     (fpu_a_value_o),
        .fpu_b_value_o     (fpu_b_value_o),
        .fpu_z_value_i     (fpu_z_value_i),
        .fpu_exec_strobe_o (fpu_exec_strobe_o),
        .fpu_done_strobe_i (fpu_done_strobe_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        e = {3'b000, x[30:23]} + 11'd896;
        if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_calc(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        real rx, ry;
        rx = sp2r(x);
        ry = sp2r(y);
        case (op)
            FPU_OP_ADD: return r2sp(rx + ry);
            FPU_OP_SUB: return r2sp(rx - ry);
            FPU_OP_MUL: return r2sp(rx * ry);
            default:    return r2sp(rx / ry);
        endcase
    endfunction

    // Intended vector of the current run; the FPU model works from this, never from the DUT.
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];
    logic [31:0] exp_c [2];

    // FPU model state.
    int          lat_fixed   = 2;
    int          m_step      = 0;
    int          m_cnt       = 0;
    int          lat_sum     = 0;
    int          run_lat     = 0;
    int          fpu_dones   = 0;
    int          done_pulses = 0;
    bit          m_busy      = 1'b0;
    bit          m_first     = 1'b0;
    bit          m_abort     = 1'b0;
    bit          m_unstable  = 1'b0;
    logic [31:0] m_va [2];
    logic [31:0] m_vb [2];
    logic [31:0] m_vc [2];
    logic [31:0] m_t  [6];
    logic [31:0] m_res, m_a_h, m_b_h;
    logic [3:0]  m_op_h;

    // Behavioural FPU: checks each issued op against the expected sequence, answers after L cycles.
    always @(negedge clk) begin
        logic [3:0]  eop;
        logic [31:0] ea, eb;
        int          lat;
        fpu_done_strobe_i = 1'b0;
        if (done_strobe_o) done_pulses++;
        if (reset_i) begin
            m_step = 0;
            if (m_busy) m_abort = 1'b1;
        end
        if (m_busy) begin
            if (m_first && !reset_i && !m_abort) check_eq("exec_strobe_pulse", {31'd0, fpu_exec_strobe_o}, 32'd0);
            if (!m_first && fpu_exec_strobe_o) m_unstable = 1'b1;
            m_first = 1'b0;
            if (!reset_i && !m_abort &&
                (fpu_op_o !== m_op_h || fpu_a_value_o !== m_a_h || fpu_b_value_o !== m_b_h))
                m_unstable = 1'b1;
            m_cnt--;
            if (m_cnt == 0) begin
                fpu_done_strobe_i = 1'b1;
                fpu_z_value_i     = m_res;
                fpu_dones++;
                m_busy = 1'b0;
                if (!m_abort) check_eq("operand_stable", {31'd0, m_unstable}, 32'd0);
                m_abort = 1'b0;
            end
        end else if (fpu_exec_strobe_o && !reset_i) begin
            if (m_step == 0) begin
                for (int i = 0; i < 2; i++) begin
                    m_va[i] = exp_a[i];
                    m_vb[i] = exp_b[i];
                    m_vc[i] = exp_c[i];
                end
                lat_sum = 0;
            end
            case (m_step)
                0: begin eop = FPU_OP_SUB; ea = m_vc[0]; eb = m_va[0]; end
                1: begin eop = FPU_OP_SUB; ea = m_vb[1]; eb = m_va[1]; end
                2: begin eop = FPU_OP_SUB; ea = m_vc[1]; eb = m_va[1]; end
                3: begin eop = FPU_OP_SUB; ea = m_vb[0]; eb = m_va[0]; end
                4: begin eop = FPU_OP_MUL; ea = m_t[0];  eb = m_t[1];  end
                5: begin eop = FPU_OP_MUL; ea = m_t[2];  eb = m_t[3];  end
                default: begin eop = FPU_OP_SUB; ea = m_t[4]; eb = m_t[5]; end
            endcase
            check_eq($sformatf("op_step%0d", m_step), {28'd0, fpu_op_o}, {28'd0, eop});
            check_eq($sformatf("opa_step%0d", m_step), fpu_a_value_o, ea);
            check_eq($sformatf("opb_step%0d", m_step), fpu_b_value_o, eb);
            m_res = fp_calc(eop, ea, eb);
            if (m_step < 6) m_t[m_step] = m_res;
            lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(10, 1));
            lat_sum += 1 + lat;
            if (m_step == 6) run_lat = lat_sum;
            m_op_h     = fpu_op_o;
            m_a_h      = fpu_a_value_o;
            m_b_h      = fpu_b_value_o;
            m_busy     = 1'b1;
            m_first    = 1'b1;
            m_unstable = 1'b0;
            m_cnt      = lat;
            m_step     = (m_step == 6) ? 0 : m_step + 1;
        end
    end

    // Vectors: a0 a1 b0 b1 c0 c1 expected_z (hand computed).
    logic [31:0] vtab [6][7];

    task automatic set_vec(input int k);
        exp_a[0] = vtab[k][0]; exp_a[1] = vtab[k][1];
        exp_b[0] = vtab[k][2]; exp_b[1] = vtab[k][3];
        exp_c[0] = vtab[k][4]; exp_c[1] = vtab[k][5];
        for (int i = 0; i < 2; i++) begin
            a_i[i] = exp_a[i];
            b_i[i] = exp_b[i];
            c_i[i] = exp_c[i];
        end
    endtask

    task automatic wait_done(output int dcyc, output bit got);
        got  = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done_strobe_o) begin
                got  = 1'b1;
                dcyc = cyc;
            end
        end
        check_eq("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic run_single(input int k, input int lat);
        int s, d;
        bit got;
        lat_fixed = lat;
        @(negedge clk);
        set_vec(k);
        exec_strobe_i = 1'b1;
        s = cyc;
        @(negedge clk);
        exec_strobe_i = 1'b0;
        // Inputs change after capture; the running computation must not see this.
        for (int i = 0; i < 2; i++) begin
            a_i[i] = 32'h40A00000;
            b_i[i] = 32'h40400000;
            c_i[i] = 32'h41200000;
        end
        wait_done(d, got);
        if (got) begin
            check_eq($sformatf("z_vec%0d", k), z_o, vtab[k][6]);
            check_eq($sformatf("latency_vec%0d", k), 32'(d - s), 32'(run_lat + 1));
            @(negedge clk);
            check_eq("done_one_cycle", {31'd0, done_strobe_o}, 32'd0);
            repeat (3) @(negedge clk);
            check_eq("z_hold", z_o, vtab[k][6]);
        end
    endtask

    initial begin
        int  s, d1, d2, base, pulses0;
        bit  got1, got2, reached;

        // 0.5=3F000000 1=3F800000 2=40000000 3=40400000 4=40800000 5=40A00000 6=40C00000
        vtab[0] = '{32'h00000000, 32'h3F000000, 32'h3F000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3E800000};
        vtab[1] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'hBF800000};
        vtab[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000};
        vtab[3] = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h00000000};
        // a=(1,1) b=(3,1) c=(1,2): 0*0 - 1*2 = -2
        vtab[4] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'hC0000000};
        // a=(1,2) b=(4,6) c=(2,5): 1*4 - 3*3 = -5
        vtab[5] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h40C00000, 32'h40000000, 32'h40A00000, 32'hC0A00000};

        reset_i       = 1'b1;
        exec_strobe_i = 1'b0;
        fpu_z_value_i = 32'd0;
        fpu_done_strobe_i = 1'b0;
        set_vec(0);

        repeat (3) @(negedge clk);
        check_eq("rst_z",        z_o, 32'd0);
        check_eq("rst_done",     {31'd0, done_strobe_o}, 32'd0);
        check_eq("rst_fpu_exec", {31'd0, fpu_exec_strobe_o}, 32'd0);
        check_eq("rst_fpu_op",   {28'd0, fpu_op_o}, 32'd0);
        check_eq("rst_fpu_a",    fpu_a_value_o, 32'd0);
        check_eq("rst_fpu_b",    fpu_b_value_o, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        run_single(0, 2);
        run_single(1, 2);
        run_single(2, 2);
        run_single(3, 2);
        run_single(4, 1);
        run_single(5, 0);
        run_single(0, 0);

        // Back-to-back: exec held high, vector swapped during the first DONE.
        lat_fixed = 0;
        @(negedge clk);
        set_vec(4);
        exec_strobe_i = 1'b1;
        s = cyc;
        wait_done(d1, got1);
        if (got1) begin
            check_eq("b2b_z_first", z_o, vtab[4][6]);
            check_eq("b2b_latency_first", 32'(d1 - s), 32'(run_lat + 1));
            set_vec(5);
            wait_done(d2, got2);
            exec_strobe_i = 1'b0;
            if (got2) begin
                check_eq("b2b_z_second", z_o, vtab[5][6]);
                check_eq("b2b_gap", 32'(d2 - d1), 32'(run_lat + 2));
            end
        end
        exec_strobe_i = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after the third FPU done with exec held high across it.
        lat_fixed = 0;
        set_vec(5);
        exec_strobe_i = 1'b1;
        base    = fpu_dones;
        pulses0 = done_pulses;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (fpu_dones >= base + 3) reached = 1'b1;
        end
        check_eq("third_fpu_done_seen", {31'd0, reached}, 32'd1);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_z",        z_o, 32'd0);
        check_eq("mid_rst_done",     {31'd0, done_strobe_o}, 32'd0);
        check_eq("mid_rst_fpu_exec", {31'd0, fpu_exec_strobe_o}, 32'd0);
        check_eq("mid_rst_fpu_op",   {28'd0, fpu_op_o}, 32'd0);
        check_eq("mid_rst_fpu_a",    fpu_a_value_o, 32'd0);
        check_eq("mid_rst_fpu_b",    fpu_b_value_o, 32'd0);
        // Hold reset longer than the worst FPU latency so the stale done lands here.
        repeat (12) @(negedge clk);
        check_eq("no_done_across_reset", 32'(done_pulses), 32'(pulses0));
        set_vec(4);
        reset_i = 1'b0;
        s = cyc;
        wait_done(d1, got1);
        exec_strobe_i = 1'b0;
        if (got1) begin
            check_eq("post_rst_z", z_o, vtab[4][6]);
            check_eq("post_rst_latency", 32'(d1 - s), 32'(run_lat + 1));
        end
        repeat (3) @(negedge clk);

        // Seven single runs, two back-to-back runs, one run after reset.
        check_eq("done_pulse_total", 32'(done_pulses), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
